disc_writer: RTL and testbench
==============================

DISC_WRITER -- requirements
Module: disc_writer

Interface
REQ-001 Parameter BITS, default 16, width of stream words; bit BITS-1 is the index flag, bits BITS-2:0 are the interval count.
REQ-002 Parameter PULSE_WIDTH, default 4, width of each write-data pulse in CLOCK cycles; legal range 1..15.
REQ-003 CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 CLKEN  in  1  interval-counter tick enable, same semantics as the reader's counter enable.
REQ-006 RUN  in  1  1 = play stream; 0 = abort and idle.
REQ-007 FD_INDEX_IN  in  1  raw index pulse from drive, asynchronous.
REQ-008 DATA  in  BITS  stream word from RAM, valid exactly one cycle after RAM_RD.
REQ-009 RAM_RD  out  1  one-cycle read strobe; RAM address advances externally per strobe.
REQ-010 FD_WRDATA  out  1  write-data pulse to drive, active-high.
REQ-011 FD_WRGATE  out  1  write gate, high while stream is playing.
REQ-012 DONE  out  1  level; terminator word reached.
REQ-013 UNDERRUN  out  1  level; next word not available at terminal count.

Function
REQ-014 Word decode: 0x0000 = terminator; 0x7FFF = carry (interval of 32767 ticks, no pulse); bit15=0 otherwise = interval N ticks, then pulse; bit15=1 = wait for index edge, then interval bits14:0 (0 there = pulse on the index edge).
REQ-015 FD_INDEX_IN is synchronised through two flops; the index event is a rising edge of the synchronised signal.
REQ-016 States: IDLE, FETCH, LOAD, WAIT_INDEX, COUNT, STOP.
REQ-017 IDLE: outputs low; RUN=1 -> FETCH.
REQ-018 FETCH: RAM_RD=1 for one cycle -> LOAD.
REQ-019 LOAD: capture DATA as current word; terminator -> STOP with DONE=1; bit15=1 -> WAIT_INDEX; else -> COUNT with counter=0; FD_WRGATE rises on first exit from LOAD to WAIT_INDEX or COUNT.
REQ-020 Prefetch: one cycle after the current word is captured, RAM_RD pulses once; next cycle DATA is captured into a one-entry next-word buffer, valid flag set.
REQ-021 WAIT_INDEX: counter held at 0; index edge -> COUNT, counter starts from that cycle; RUN may wait indefinitely.
REQ-022 COUNT: counter (BITS-1 bits) increments on CLKEN; terminal when CLKEN=1 and counter==N-1.
REQ-023 At terminal: FD_WRDATA asserted starting next cycle for PULSE_WIDTH cycles unless word is carry; buffered word becomes current, counter=0, buffer valid cleared, new prefetch strobe next cycle.
REQ-024 New current word is decoded on terminal exactly as in LOAD (terminator -> STOP, index -> WAIT_INDEX); pulse in progress completes regardless.
REQ-025 Terminal with buffer invalid -> STOP, UNDERRUN=1, pulse still issued.
REQ-026 Pulse timer independent of CLKEN; a new pulse starting before the previous ends restarts the timer (no gap).
REQ-027 STOP: FD_WRGATE=0 once any pending pulse finishes; DONE/UNDERRUN held until RUN=0, then -> IDLE with flags cleared.
REQ-028 RUN=0 in any state: next cycle state=IDLE, FD_WRDATA=0 (pulse truncated), FD_WRGATE=0, buffer invalid, RAM_RD=0.
REQ-029 RUN=1 and CLKEN=1 at FETCH/LOAD have no counting effect.

Reset
REQ-030 RESET=1 forces immediately: state=IDLE, RAM_RD=0, FD_WRDATA=0, FD_WRGATE=0, DONE=0, UNDERRUN=0, counter=0, buffer invalid, synchronisers=0.
REQ-031 After RESET falls with RUN=1, first RAM_RD occurs on the second rising edge.

Verification
REQ-032 CLKEN=1 always, stream 0x0005,0x0003,0x0000 -> WRGATE high, pulses 5 and then 3 cycles apart (start-to-start), each PULSE_WIDTH=4 wide, DONE=1, WRGATE low after last pulse.
REQ-033 Stream 0x7FFF,0x0002,0x0000, CLKEN=1 -> no pulse for 32767 ticks, one pulse 32769 ticks after counting starts, DONE=1.
REQ-034 Stream 0x8003,0x0000; index edge at cycle 100 -> counter held until edge, pulse starts 3 ticks plus 1 cycle after synchronised edge.
REQ-035 CLKEN one cycle in four, stream 0x0002,... -> pulse interval 8 CLOCK cycles; stream 0x0001 with CLKEN=1 -> UNDERRUN=1 at the first terminal.
REQ-036 RUN dropped mid-pulse -> FD_WRDATA and FD_WRGATE low next cycle, state IDLE; RESET asserted mid-COUNT -> all outputs 0 without a clock edge.
REQ-037 Round-trip: feed FD_WRDATA into the reader with shared CLKEN -> captured counts equal the written intervals.

Source files
------------

// File: rtl/disc_writer.sv
// Floppy write-stream player: fetches interval words from RAM, times each interval on
// CLKEN ticks and emits a fixed-width write-data pulse at every non-carry terminal count.
module disc_writer #(
    parameter int BITS        = 16,
    parameter int PULSE_WIDTH = 4
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            CLKEN,
    input  logic            RUN,
    input  logic            FD_INDEX_IN,
    input  logic [BITS-1:0] DATA,
    output logic            RAM_RD,
    output logic            FD_WRDATA,
    output logic            FD_WRGATE,
    output logic            DONE,
    output logic            UNDERRUN
);
    localparam int NW = BITS - 1;
    localparam logic [NW-1:0] CARRY_N = '1;
    localparam logic [NW-1:0] ONE_N   = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    PW      = 4'(PULSE_WIDTH);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_INDEX, COUNT, STOP} state_t;

    state_t          state, state_nx;
    logic [BITS-1:0] cur_word, next_word, word_src;
    logic            next_vld, pf_rd, pf_cap;
    logic [NW-1:0]   cnt, interval;
    logic [3:0]      pulse_cnt;
    logic            sync1, sync2, sync3;
    logic            done_r, underrun_r;
    logic            is_carry, idx_edge, terminal, next_avail;
    logic            load_word, start_pf, set_done, set_under;

    function automatic state_t decode(input logic [BITS-1:0] w);
        if (w == '0) return STOP;
        if (w[BITS-1]) return WAIT_INDEX;
        return COUNT;
    endfunction

    always_comb begin
        interval   = cur_word[NW-1:0];
        is_carry   = !cur_word[BITS-1] && (interval == CARRY_N);
        idx_edge   = sync2 && !sync3;
        // The prefetched word may still be on DATA in its capture cycle; use it directly.
        next_avail = next_vld || pf_cap;
        word_src   = (state == LOAD) ? DATA : (next_vld ? next_word : DATA);
        terminal   = ((state == COUNT) && CLKEN && (cnt == interval - ONE_N))
                  || ((state == WAIT_INDEX) && idx_edge && (interval == '0));
        state_nx   = state;
        load_word  = 1'b0;
        set_under  = 1'b0;
        case (state)
            IDLE:  if (RUN) state_nx = FETCH;
            FETCH: state_nx = LOAD;
            LOAD: begin
                load_word = 1'b1;
                state_nx  = decode(DATA);
            end
            WAIT_INDEX, COUNT: begin
                if (terminal) begin
                    if (next_avail) begin
                        load_word = 1'b1;
                        state_nx  = decode(word_src);
                    end else begin
                        set_under = 1'b1;
                        state_nx  = STOP;
                    end
                end else if ((state == WAIT_INDEX) && idx_edge) begin
                    state_nx = COUNT;
                end
            end
            STOP:    state_nx = STOP;
            default: state_nx = IDLE;
        endcase
        set_done = load_word && (word_src == '0);
        start_pf = load_word && (word_src != '0);
        if (!RUN) state_nx = IDLE;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            next_vld   <= 1'b0;
            pf_rd      <= 1'b0;
            pf_cap     <= 1'b0;
            cnt        <= '0;
            pulse_cnt  <= '0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state <= state_nx;
            sync1 <= FD_INDEX_IN;
            sync2 <= sync1;
            sync3 <= sync2;
            if (!RUN) begin
                next_vld   <= 1'b0;
                pf_rd      <= 1'b0;
                pf_cap     <= 1'b0;
                cnt        <= '0;
                pulse_cnt  <= '0;
                done_r     <= 1'b0;
                underrun_r <= 1'b0;
            end else begin
                pf_rd  <= start_pf;
                pf_cap <= pf_rd;
                if (terminal)    next_vld <= 1'b0;
                else if (pf_cap) next_vld <= 1'b1;
                if ((state == COUNT) && !terminal) begin
                    if (CLKEN) cnt <= cnt + ONE_N;
                end else begin
                    cnt <= '0;
                end
                // A new pulse restarts the timer, so back-to-back pulses merge without a gap.
                if (terminal && !is_carry) pulse_cnt <= PW;
                else if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
                if (set_done)  done_r     <= 1'b1;
                if (set_under) underrun_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (load_word) cur_word  <= word_src;
        if (pf_cap)    next_word <= DATA;
    end

    assign RAM_RD    = (state == FETCH) || pf_rd;
    assign FD_WRDATA = (pulse_cnt != 4'd0);
    assign FD_WRGATE = (state == WAIT_INDEX) || (state == COUNT) || ((state == STOP) && FD_WRDATA);
    assign DONE      = done_r;
    assign UNDERRUN  = underrun_r;
endmodule

// File: tb/tb_disc_writer.sv
// Bench for disc_writer: hand-derived vector table, corner sequences, and random streams
// checked against a tick-counting reference model.
module tb_disc_writer;
    localparam int BITS = 16;
    localparam int PW   = 4;
    localparam int MAXC = 33000;

    typedef struct {
        logic [63:0] words;
        int          nw;
        int          ce_per;
        int          idx_at;
        logic [63:0] wr;
        logic [63:0] gate;
        bit          done;
        bit          under;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, clken, run, idx, ram_clr;
    logic        ram_rd, wrdata, wrgate, done, under;
    logic [15:0] data;
    logic [15:0] mem [0:63];
    logic [5:0]  addr;
    bit          ce_arr [0:MAXC-1];
    bit          logs [0:3][0:MAXC-1];
    bit          exps [0:3][0:MAXC-1];
    vec_t        tbl [0:6];
    int          tests = 0;
    int          fails = 0;

    disc_writer #(.BITS(BITS), .PULSE_WIDTH(PW)) dut (
        .CLOCK(clk), .RESET(rst), .CLKEN(clken), .RUN(run), .FD_INDEX_IN(idx),
        .DATA(data), .RAM_RD(ram_rd), .FD_WRDATA(wrdata), .FD_WRGATE(wrgate),
        .DONE(done), .UNDERRUN(under)
    );

    always #5 clk = ~clk;

    // RAM: word appears on DATA the cycle after the strobe, address advances per strobe.
    always @(posedge clk) begin
        if (ram_clr) addr <= '0;
        else if (ram_rd) begin
            data <= mem[addr];
            addr <= addr + 6'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic check_wave(input string name, input int which, input int len);
        int bad = -1;
        for (int c = 0; c < len; c++)
            if (bad < 0 && logs[which][c] != exps[which][c]) bad = c;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: cycle %0d got %0d, expected %0d", name, bad,
                     logs[which][bad], exps[which][bad]);
        end
    endtask

    task automatic clear_mem_exp();
        for (int k = 0; k < 64; k++) mem[k] = 16'h0000;
        for (int w = 0; w < 4; w++)
            for (int c = 0; c < MAXC; c++) exps[w][c] = 1'b0;
    endtask

    // Cycle 0 is the cycle in which RUN rises; one log entry per cycle.
    task automatic run_case(input int len, input int idx_at);
        @(negedge clk); ram_clr = 1'b1; run = 1'b0; idx = 1'b0;
        @(negedge clk); ram_clr = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            logs[0][c] = wrdata;
            logs[1][c] = wrgate;
            logs[2][c] = done;
            logs[3][c] = under;
            if (c == 0) run = 1'b1;
            clken = ce_arr[c];
            idx = (idx_at >= 0) && (c >= idx_at) && (c < idx_at + 3);
        end
    endtask

    task automatic finish_case(input string name);
        run = 1'b0;
        idx = 1'b0;
        @(negedge clk);
        check({name, "_abort"}, int'({wrdata, wrgate, ram_rd, done, under}), 0);
        @(negedge clk);
    endtask

    // Reference model: walk the stream word by word, counting CLKEN ticks per interval.
    // A word only has its successor available from its second cycle onward.
    task automatic model_run(output int stop_c);
        int s, c, ticks, n, k;
        bit dn, un;
        int pst[$];
        s = 3; dn = 0; un = 0; stop_c = 3;
        for (k = 0; k < 64; k++) begin
            if (mem[k] == 16'h0000) begin
                dn = 1; stop_c = s; break;
            end
            n = int'(mem[k][14:0]);
            ticks = 0;
            c = s;
            while (c < MAXC - 20) begin
                if (ce_arr[c]) ticks++;
                if (ticks == n) break;
                c++;
            end
            if (mem[k] != 16'h7FFF) pst.push_back(c + 1);
            if (c == s) begin
                un = 1; stop_c = c + 1; break;
            end
            s = c + 1;
        end
        foreach (pst[i])
            for (int j = 0; j < PW; j++) exps[0][pst[i] + j] = 1'b1;
        for (int t = 0; t < MAXC; t++) begin
            exps[1][t] = ((t >= 3) && (t < stop_c)) || ((t >= stop_c) && exps[0][t]);
            exps[2][t] = dn && (t >= stop_c);
            exps[3][t] = un && (t >= stop_c);
        end
    endtask

    initial begin
        int stop_c, len, first_hi, hi_cnt, mode;

        tbl[0] = '{64'h0000_0000_0003_0005, 3, 1, -1, 64'h7F00,     64'h7FF8,     1'b1, 1'b0};
        tbl[1] = '{64'h0000_0000_0005_0001, 2, 1, -1, 64'hF0,       64'hF8,       1'b0, 1'b1};
        tbl[2] = '{64'h0000_0000_0002_0002, 3, 4, -1, 64'h1E1E00,   64'h1FFFF8,   1'b1, 1'b0};
        tbl[3] = '{64'h0000_0000_0000_0000, 1, 1, -1, 64'h0,        64'h0,        1'b1, 1'b0};
        tbl[4] = '{64'h0000_0000_0002_0003, 3, 1, -1, 64'hFC0,      64'hFF8,      1'b1, 1'b0};
        tbl[5] = '{64'h0000_0000_0000_8003, 2, 1, 20, 64'h3C000000, 64'h3FFFFFF8, 1'b1, 1'b0};
        tbl[6] = '{64'h0000_0000_0000_8000, 2, 1, 20, 64'h07800000, 64'h07FFFFF8, 1'b1, 1'b0};

        rst = 1'b1; run = 1'b0; clken = 1'b0; idx = 1'b0; ram_clr = 1'b1;
        for (int k = 0; k < 64; k++) mem[k] = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_ram_rd",   int'(ram_rd), 0);
        check("reset_wrdata",   int'(wrdata), 0);
        check("reset_wrgate",   int'(wrgate), 0);
        check("reset_done",     int'(done),   0);
        check("reset_underrun", int'(under),  0);
        rst = 1'b0; ram_clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            clear_mem_exp();
            for (int k = 0; k < tbl[i].nw; k++) mem[k] = tbl[i].words[16*k +: 16];
            for (int c = 0; c < MAXC; c++) ce_arr[c] = ((c % tbl[i].ce_per) == 0);
            for (int c = 0; c < 64; c++) begin
                exps[0][c] = tbl[i].wr[c];
                exps[1][c] = tbl[i].gate[c];
            end
            run_case(64, tbl[i].idx_at);
            check_wave($sformatf("tbl%0d_wrdata", i), 0, 64);
            check_wave($sformatf("tbl%0d_wrgate", i), 1, 64);
            check($sformatf("tbl%0d_done", i),     int'(logs[2][63]), int'(tbl[i].done));
            check($sformatf("tbl%0d_underrun", i), int'(logs[3][63]), int'(tbl[i].under));
            finish_case($sformatf("tbl%0d", i));
        end

        clear_mem_exp();
        mem[0] = 16'h7FFF; mem[1] = 16'h0002;
        for (int c = 0; c < MAXC; c++) ce_arr[c] = 1'b1;
        model_run(stop_c);
        run_case(32790, -1);
        check_wave("carry_wrdata", 0, 32790);
        check_wave("carry_wrgate", 1, 32790);
        first_hi = -1; hi_cnt = 0;
        for (int c = 0; c < 32790; c++) begin
            if (logs[0][c]) hi_cnt++;
            if (first_hi < 0 && logs[0][c]) first_hi = c;
        end
        check("carry_first_pulse", first_hi, 32772);
        check("carry_pulse_width", hi_cnt, PW);
        check("carry_done", int'(logs[2][32789]), 1);
        finish_case("carry");

        clear_mem_exp();
        mem[0] = 16'h0005; mem[1] = 16'h0003;
        for (int c = 0; c < MAXC; c++) ce_arr[c] = 1'b1;
        run_case(10, -1);
        check("midpulse_active", int'(logs[0][9]), 1);
        finish_case("midpulse");

        clear_mem_exp();
        mem[0] = 16'd20;
        run_case(8, -1);
        check("midcount_gate", int'(logs[1][7]), 1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", int'({wrdata, wrgate, ram_rd, done, under}), 0);
        @(negedge clk); ram_clr = 1'b1;
        @(negedge clk); rst = 1'b0; ram_clr = 1'b0;
        #1 check("post_reset_no_rd", int'(ram_rd), 0);
        @(negedge clk);
        check("post_reset_first_rd", int'(ram_rd), 1);
        @(negedge clk);
        check("post_reset_rd_one_cycle", int'(ram_rd), 0);
        finish_case("post_reset");

        for (int r = 0; r < 20; r++) begin
            int nw;
            clear_mem_exp();
            nw = int'($urandom_range(1, 6));
            for (int k = 0; k < nw; k++) mem[k] = 16'($urandom_range(1, 9));
            mode = int'($urandom_range(0, 2));
            for (int c = 0; c < MAXC; c++)
                ce_arr[c] = (mode == 0) ? 1'b1 :
                            (mode == 1) ? ($urandom_range(0, 1) == 0) :
                                          ($urandom_range(0, 3) == 0);
            model_run(stop_c);
            len = stop_c + 10;
            run_case(len, -1);
            check_wave($sformatf("rnd%0d_wrdata", r),   0, len);
            check_wave($sformatf("rnd%0d_wrgate", r),   1, len);
            check_wave($sformatf("rnd%0d_done", r),     2, len);
            check_wave($sformatf("rnd%0d_underrun", r), 3, len);
            finish_case($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
